// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: framing bytes, command codes,
// error codes, FSM state encoding and the captured-frame payload.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

    localparam logic [ERR_W-1:0] ERR_NONE        = 2'd0;
    localparam logic [ERR_W-1:0] ERR_CHECKSUM    = 2'd1;
    localparam logic [ERR_W-1:0] ERR_UNKNOWN_CMD = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT     = 2'd3;

    localparam logic [STATE_W-1:0] S_SYNC = 3'd0;
    localparam logic [STATE_W-1:0] S_CMD  = 3'd1;
    localparam logic [STATE_W-1:0] S_ADDR = 3'd2;
    localparam logic [STATE_W-1:0] S_DHI  = 3'd3;
    localparam logic [STATE_W-1:0] S_DLO  = 3'd4;
    localparam logic [STATE_W-1:0] S_CHK  = 3'd5;

    // Shadow copy of a frame's payload while it is being received
    typedef struct packed {
        logic [BYTE_W-1:0] cmd;
        logic [BYTE_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in from the UART receiver and register-access strobes out.
interface uart_cmd_parser_if;
    import uart_cmd_pkg::*;

    logic                i_Rx_DV;
    logic [BYTE_W-1:0]   i_Rx_Byte;
    logic                o_Wr_En;
    logic                o_Rd_Req;
    logic [BYTE_W-1:0]   o_Addr;
    logic [DATA_W-1:0]   o_Wr_Data;
    logic                o_Err;
    logic [ERR_W-1:0]    o_Err_Code;

    modport master (
        output i_Rx_DV, i_Rx_Byte,
        input  o_Wr_En, o_Rd_Req, o_Addr, o_Wr_Data, o_Err, o_Err_Code
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte,
        output o_Wr_En, o_Rd_Req, o_Addr, o_Wr_Data, o_Err, o_Err_Code
    );

endinterface

// File: rtl/uart_timeout_ctr.sv
// Saturating inter-byte timeout counter; expire_o is high while the count
// sits at CLKS-1.
module uart_timeout_ctr #(
    parameter int unsigned CLKS = 8680,
    parameter int unsigned BITS = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [BITS-1:0] CNT_MAX   = '1;
    localparam logic [BITS-1:0] EXPIRE_AT = BITS'(CLKS - 1);

    logic [BITS-1:0] cnt_q, cnt_d;
    logic            expire_q, expire_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + BITS'(1);
        end
        expire_d = (cnt_d == EXPIRE_AT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 6-byte SYNC/CMD/ADDR/DHI/DLO/CHK frames from a UART byte stream into
// one-cycle register write/read strobes or frame-error strobes.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 8680,
    parameter int unsigned TIMEOUT_BITS = 14
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    uart_cmd_parser_if.slave bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [BYTE_W-1:0]  chk_q, chk_d;
    frame_t             frame_q, frame_d;
    logic [BYTE_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_req_q, rd_req_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_code_q, err_code_d;

    logic               tmo_clear_c;
    logic               tmo_enable_c;
    logic               tmo_expire;

    // Idle in S_SYNC keeps the counter parked at zero
    assign tmo_clear_c  = bus.i_Rx_DV || (state_q == S_SYNC);
    assign tmo_enable_c = (state_q != S_SYNC);

    uart_timeout_ctr #(
        .CLKS (TIMEOUT_CLKS),
        .BITS (TIMEOUT_BITS)
    ) u_timeout_ctr (
        .clk      (i_Clock),
        .rst_n    (i_Reset_n),
        .clear_i  (tmo_clear_c),
        .enable_i (tmo_enable_c),
        .expire_o (tmo_expire)
    );

    // Next-state and output decode; a byte always beats a simultaneous timeout
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        frame_d    = frame_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (bus.i_Rx_DV) begin
            case (state_q)
                S_SYNC: begin
                    if (bus.i_Rx_Byte == SYNC_BYTE) begin
                        state_d = S_CMD;
                        chk_d   = '0;
                    end
                end
                S_CMD: begin
                    frame_d.cmd = bus.i_Rx_Byte;
                    chk_d       = chk_q ^ bus.i_Rx_Byte;
                    state_d     = S_ADDR;
                end
                S_ADDR: begin
                    frame_d.addr = bus.i_Rx_Byte;
                    chk_d        = chk_q ^ bus.i_Rx_Byte;
                    state_d      = S_DHI;
                end
                S_DHI: begin
                    frame_d.data[DATA_W-1:BYTE_W] = bus.i_Rx_Byte;
                    chk_d   = chk_q ^ bus.i_Rx_Byte;
                    state_d = S_DLO;
                end
                S_DLO: begin
                    frame_d.data[BYTE_W-1:0] = bus.i_Rx_Byte;
                    chk_d   = chk_q ^ bus.i_Rx_Byte;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_SYNC;
                    if (bus.i_Rx_Byte != chk_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end else if (frame_q.cmd == CMD_WRITE) begin
                        wr_en_d = 1'b1;
                        addr_d  = frame_q.addr;
                        wdata_d = frame_q.data;
                    end else if (frame_q.cmd == CMD_READ) begin
                        rd_req_d = 1'b1;
                        addr_d   = frame_q.addr;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNKNOWN_CMD;
                    end
                end
                default: begin
                    state_d = S_SYNC;
                end
            endcase
        end else if ((state_q != S_SYNC) && tmo_expire) begin
            state_d    = S_SYNC;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= S_SYNC;
            chk_q      <= '0;
            frame_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            frame_q    <= frame_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.o_Wr_En    = wr_en_q;
    assign bus.o_Rd_Req   = rd_req_q;
    assign bus.o_Addr     = addr_q;
    assign bus.o_Wr_Data  = wdata_q;
    assign bus.o_Err      = err_q;
    assign bus.o_Err_Code = err_code_q;

endmodule
